// File: rtl/reaction_timer.sv
// Lane-side drag-race judge: red-light foul detection and green-to-release reaction timing in ms.
// Optional macro RT_BCD_EN selects a 4-digit BCD RT output instead of binary.
module reaction_timer #(
    parameter int TICK_DIV = 50_000,
    parameter int MAX_MS   = 9999
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Clr,
    input  logic        SB,
    input  logic        A1,
    input  logic        G,
    input  logic        R,
    output logic [15:0] RT,
    output logic        Valid,
    output logic        Foul,
    output logic        Timeout,
    output logic        Busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]   MS_LAST    = 14'(MAX_MS - 1);

    typedef enum logic [2:0] {
        IDLE, ARMED, TREE, TIMING, DONE, FOUL, TMO
    } state_t;

    state_t        state, next;
    logic          sb_meta, sbs;
    logic [PW-1:0] presc;
    logic [13:0]   ms;
    logic          tick;
    logic [15:0]   count_rt;
    logic [15:0]   max_rt;

`ifdef RT_BCD_EN
    localparam logic [15:0] MAX_BCD = {4'((MAX_MS / 1000) % 10), 4'((MAX_MS / 100) % 10),
                                       4'((MAX_MS / 10) % 10), 4'(MAX_MS % 10)};
    logic [15:0] bcd;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bcd <= '0;
        end else if (state == TREE) begin
            bcd <= '0;
        end else if (state == TIMING && tick) begin
            bcd <= bcd_inc(bcd);
        end
    end

    assign count_rt = bcd;
    assign max_rt   = MAX_BCD;
`else
    assign count_rt = {2'b00, ms};
    assign max_rt   = 16'(MAX_MS);
`endif

    assign tick = (presc == PRESC_LAST);

    // Stage beam is asynchronous to the board clock.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sb_meta <= 1'b0;
            sbs     <= 1'b0;
        end else begin
            sb_meta <= SB;
            sbs     <= sb_meta;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   if (sbs) next = ARMED;
            ARMED: begin
                if (!sbs)    next = IDLE;
                else if (A1) next = TREE;
            end
            TREE: begin
                if (R)              next = FOUL;
                else if (G && !sbs) next = DONE;
                else if (!sbs)      next = FOUL;
                else if (G)         next = TIMING;
            end
            TIMING: begin
                if (!sbs)                        next = DONE;
                else if (tick && ms == MS_LAST)  next = TMO;
            end
            DONE, FOUL, TMO: if (Clr) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Flags are decoded from the upcoming state so they appear one cycle after the deciding sample.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            presc   <= '0;
            ms      <= '0;
            RT      <= '0;
            Valid   <= 1'b0;
            Foul    <= 1'b0;
            Timeout <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state   <= next;
            Valid   <= (next == DONE);
            Foul    <= (next == FOUL);
            Timeout <= (next == TMO);
            Busy    <= (next == TREE) || (next == TIMING);

            if (state == TREE) begin
                presc <= '0;
                ms    <= '0;
            end else if (state == TIMING) begin
                if (tick) begin
                    presc <= '0;
                    ms    <= ms + 14'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            case (state)
                TREE:   if (next == DONE) RT <= '0;
                TIMING: begin
                    if (next == DONE)     RT <= count_rt;
                    else if (next == TMO) RT <= max_rt;
                end
                DONE, FOUL, TMO: if (next == IDLE) RT <= '0;
                default: ;
            endcase
        end
    end

endmodule
